wb_ram_arbiter: RTL and testbench

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

---
 rtl/wb_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_ram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one RAM slave port,
// with a per-transfer stall timeout that terminates the owner with an error.
module wb_ram_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0] wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [AW-1:0]             wbs_adr_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [DW-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [GW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy, timeout, term, found;
    int                     idx;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // last_q always names the current owner while BUSY
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        found   = 1'b0;
        idx     = 0;
        busy    = (state_q == BUSY);
        timeout = busy && wbm_cyc_i[last_q] && (cnt_q == CW'(TIMEOUT));
        term    = busy && (wbs_ack_i || wbs_err_i || wbs_rty_i || timeout);
        unique case (state_q)
            IDLE: begin
                if (|wbm_cyc_i) begin
                    for (int i = 1; i <= NUM_MASTERS; i++) begin
                        idx = (int'(last_q) + i) % NUM_MASTERS;
                        if (!found && wbm_cyc_i[idx]) begin
                            found        = 1'b1;
                            last_d       = GW'(idx);
                            grant_d      = '0;
                            grant_d[idx] = 1'b1;
                        end
                    end
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!wbm_cyc_i[last_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (term) begin
                    cnt_d = '0;
                end else if (wbm_stb_i[last_q]) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        grant_o   = grant_q;
        if (busy) begin
            wbs_adr_o = wbm_adr_i[int'(last_q)*AW +: AW];
            wbs_dat_o = wbm_dat_i[int'(last_q)*DW +: DW];
            wbs_sel_o = wbm_sel_i[int'(last_q)*4 +: 4];
            wbs_cti_o = wbm_cti_i[int'(last_q)*3 +: 3];
            wbs_bte_o = wbm_bte_i[int'(last_q)*2 +: 2];
            wbs_we_o  = wbm_we_i[last_q];
            wbs_cyc_o = wbm_cyc_i[last_q];
            wbs_stb_o = wbm_stb_i[last_q] && !timeout;
            wbm_ack_o[last_q] = wbs_ack_i && !timeout;
            wbm_err_o[last_q] = wbs_err_i || timeout;
            wbm_rty_o[last_q] = wbs_rty_i && !timeout;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed scenarios plus a randomized run checked against a
// transaction-level ownership model of the arbiter.
module tb_wb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] adr, dat, mdat;
    logic [11:0] sel;
    logic [2:0]  we, cyc, stb, ack, err, rty, grant;
    logic [8:0]  cti;
    logic [5:0]  bte;
    logic [31:0] wadr, wdat, sdat;
    logic [3:0]  wsel;
    logic        wwe, wcyc, wstb, sack, serr, srty;
    logic [2:0]  wcti;
    logic [1:0]  wbte;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter dut (
        .wb_clk_i (clk),   .wb_rst_i (rst),
        .wbm_adr_i(adr),   .wbm_dat_i(dat),  .wbm_sel_i(sel),
        .wbm_we_i (we),    .wbm_cyc_i(cyc),  .wbm_stb_i(stb),
        .wbm_cti_i(cti),   .wbm_bte_i(bte),  .wbm_dat_o(mdat),
        .wbm_ack_o(ack),   .wbm_err_o(err),  .wbm_rty_o(rty),
        .wbs_adr_o(wadr),  .wbs_dat_o(wdat), .wbs_sel_o(wsel),
        .wbs_we_o (wwe),   .wbs_cyc_o(wcyc), .wbs_stb_o(wstb),
        .wbs_cti_o(wcti),  .wbs_bte_o(wbte), .wbs_dat_i(sdat),
        .wbs_ack_i(sack),  .wbs_err_i(serr), .wbs_rty_i(srty),
        .grant_o  (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic drop(input int m);
        cyc[m] = 1'b0;
        stb[m] = 1'b0;
    endtask

    task automatic raise(input int m);
        cyc[m] = 1'b1;
        stb[m] = 1'b1;
    endtask

    // round-robin pick: first requester after the previous owner
    function automatic int rr(input int lst, input logic [2:0] c);
        for (int i = 1; i <= 3; i++) begin
            if (c[(lst + i) % 3]) return (lst + i) % 3;
        end
        return -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int owner, last;
        int rem[3];
        logic ackseen;
        logic [2:0] seen;
        logic [2:0] expg;

        rst = 1'b1; cyc = '0; stb = '0; cti = '0; bte = '0; we = 3'b101;
        sack = 0; serr = 0; srty = 0; sdat = 32'hD5D5_0001;
        for (int m = 0; m < 3; m++) begin
            adr[m*32 +: 32] = 32'hA000_0000 | m;
            dat[m*32 +: 32] = 32'h1111_1111 * (m + 1);
            sel[m*4 +: 4]   = 4'h1 << m;
        end
        #3 cyc = 3'b111; stb = 3'b111; sack = 1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_wcyc", wcyc, 0);
        chk("rst_wstb", wstb, 0);
        chk("rst_wadr", wadr, 0);
        chk("rst_ack", ack, 0);
        nxt; nxt;
        sack = 0; rst = 0;
        #1 chk("lat_before_edge", grant, 0);
        // three masters finish single accesses in rotation
        nxt; #1;
        chk("rr_g0", grant, 3'b001);
        chk("rr_wcyc0", wcyc, 1);
        chk("rr_wadr0", wadr, 32'hA000_0000);
        chk("rr_wsel0", wsel, 4'h1);
        chk("rr_wdat0", wdat, 32'h1111_1111);
        chk("rr_mdat2", mdat[64 +: 32], 32'hD5D5_0001);
        sack = 1;
        #1 chk("rr_ack0", ack, 3'b001);
        nxt; sack = 0; drop(0);
        #1 chk("rr_hold0", grant, 3'b001);
        nxt; #1 chk("rr_dead01", grant, 0);
        nxt; #1 chk("rr_g1", grant, 3'b010);
        chk("rr_wadr1", wadr, 32'hA000_0001);
        chk("rr_wwe1", wwe, 0);
        sack = 1;
        #1 chk("rr_ack1", ack, 3'b010);
        nxt; sack = 0; drop(1);
        nxt; #1 chk("rr_dead12", grant, 0);
        nxt; #1 chk("rr_g2", grant, 3'b100);
        chk("rr_wadr2", wadr, 32'hA000_0002);
        sack = 1;
        #1 chk("rr_ack2", ack, 3'b100);
        nxt; sack = 0; drop(2);
        nxt; #1;
        chk("idle_grant", grant, 0);
        chk("idle_wadr", wadr, 0);

        // 8-beat incrementing burst of master 1 with master 2 waiting
        nxt; raise(1); cti[5:3] = 3'b010;
        nxt; #1 chk("burst_g1", grant, 3'b010);
        raise(2);
        for (int b = 0; b < 8; b++) begin
            cti[5:3] = (b == 7) ? 3'b111 : 3'b010;
            adr[32 +: 32] = 32'hB000_0000 + 4 * b;
            sack = 1;
            #1;
            chk("burst_ack", ack, 3'b010);
            chk("burst_grant", grant, 3'b010);
            chk("burst_cti", wcti, (b == 7) ? 3'b111 : 3'b010);
            chk("burst_adr", wadr, 32'hB000_0000 + 4 * b);
            nxt;
        end
        sack = 0; drop(1); cti[5:3] = 0;
        #1 chk("burst_hold", grant, 3'b010);
        nxt; #1 chk("burst_dead", grant, 0);
        nxt; #1 chk("burst_next", grant, 3'b100);

        // slave error routed to master 2 only, grant retained
        serr = 1;
        #1;
        chk("err_route", err, 3'b100);
        chk("err_noack", ack, 0);
        nxt; serr = 0;
        #1 chk("err_clear", err, 0);
        chk("err_keep", grant, 3'b100);
        nxt; #1 chk("err_keep2", grant, 3'b100);
        drop(2);
        nxt; #1 chk("err_release", grant, 0);

        // slave never answers: timeout error
        raise(0);
        nxt; #1 chk("to_grant", grant, 3'b001);
        k = 0; ackseen = 0;
        while (err[0] !== 1'b1 && k < 400) begin
            if (|ack) ackseen = 1;
            nxt; #1;
            k++;
        end
        chk("to_cycles", k, 255);
        chk("to_err", err, 3'b001);
        chk("to_stb", wstb, 0);
        chk("to_noack", ackseen, 0);
        nxt; #1;
        chk("to_pulse", err, 0);
        chk("to_hold", grant, 3'b001);
        drop(0);
        nxt; #1 chk("to_release", grant, 0);

        // asynchronous reset in the middle of a burst
        raise(0); cti[2:0] = 3'b010;
        nxt; #1 chk("ar_grant", grant, 3'b001);
        sack = 1;
        nxt; #1 raise(2);
        #2 rst = 1;
        #1;
        chk("ar_grant0", grant, 0);
        chk("ar_wcyc", wcyc, 0);
        chk("ar_wstb", wstb, 0);
        chk("ar_wadr", wadr, 0);
        chk("ar_ack", ack, 0);
        nxt; rst = 0; sack = 0;
        #1 chk("ar_idle", grant, 0);
        nxt; #1 chk("ar_first", grant, 3'b001);

        // randomized traffic against the ownership model
        rst = 1; cyc = '0; stb = '0; cti = '0;
        nxt; rst = 0;
        owner = -1; last = 2; seen = '0;
        for (int m = 0; m < 3; m++) rem[m] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 3; m++) begin
                if (cyc[m] && seen[m]) begin
                    rem[m]--;
                    if (rem[m] == 0) drop(m);
                end else if (!cyc[m] && ($urandom % 3 == 0)) begin
                    raise(m);
                    rem[m] = 1 + $urandom % 4;
                    adr[m*32 +: 32] = $urandom;
                    dat[m*32 +: 32] = $urandom;
                    we[m] = $urandom % 2;
                end
            end
            sack = $urandom % 2;
            sdat = $urandom;
            #1;
            expg = (owner >= 0) ? (3'b001 << owner) : 3'b000;
            chk("rnd_grant", grant, expg);
            chk("rnd_ack", ack, sack ? expg : 3'b000);
            chk("rnd_wcyc", wcyc, (owner >= 0) ? cyc[owner] : 1'b0);
            if (owner >= 0) begin
                chk("rnd_wadr", wadr, adr[owner*32 +: 32]);
                chk("rnd_wdat", wdat, dat[owner*32 +: 32]);
            end
            seen = ack;
            @(posedge clk);
            if (owner >= 0) begin
                if (!cyc[owner]) owner = -1;
            end else begin
                owner = rr(last, cyc);
                if (owner >= 0) last = owner;
            end
            #2;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
